// File: rtl/decode_stage.sv
// copperv RV32I decode stage: combinational decode into a
// two-entry (output + skid) registered buffer with valid/ready flow control.

package copperv_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int OPCODE_WIDTH    = 7;
    localparam int INST_TYPE_WIDTH = 4;
    localparam int IMM_WIDTH       = 32;
    localparam int REG_WIDTH       = 5;
    localparam int FUNCT_WIDTH     = 5;

    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_ILLEGAL = 4'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 4'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_AUIPC   = 4'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 4'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JALR    = 4'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 4'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_LOAD    = 4'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 4'd7;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 4'd8;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 4'd9;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE       = 5'd0;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD        = 5'd1;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB        = 5'd2;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL        = 5'd3;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT        = 5'd4;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU       = 5'd5;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR        = 5'd6;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL        = 5'd7;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA        = 5'd8;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR         = 5'd9;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND        = 5'd10;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ         = 5'd11;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NEQ        = 5'd12;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LT         = 5'd13;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTE        = 5'd14;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LTU        = 5'd15;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTEU       = 5'd16;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTE   = 5'd17;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORD  = 5'd18;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_WORD   = 5'd19;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTEU  = 5'd20;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORDU = 5'd21;

    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]    opcode;
        logic [INST_TYPE_WIDTH-1:0] inst_type;
        logic [IMM_WIDTH-1:0]       imm;
        logic [REG_WIDTH-1:0]       rd;
        logic [REG_WIDTH-1:0]       rs1;
        logic [REG_WIDTH-1:0]       rs2;
        logic [FUNCT_WIDTH-1:0]     funct;
        logic                       illegal;
    } dec_t;

endpackage

module decode_stage
    import copperv_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       inst_valid,
    output logic                       inst_ready,
    input  logic [INST_WIDTH-1:0]      inst,
    input  logic [PC_WIDTH-1:0]        inst_pc,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [PC_WIDTH-1:0]        dec_pc,
    output logic [OPCODE_WIDTH-1:0]    opcode,
    output logic [INST_TYPE_WIDTH-1:0] inst_type,
    output logic [IMM_WIDTH-1:0]       imm,
    output logic [REG_WIDTH-1:0]       rd,
    output logic [REG_WIDTH-1:0]       rs1,
    output logic [REG_WIDTH-1:0]       rs2,
    output logic [FUNCT_WIDTH-1:0]     funct,
    output logic                       illegal,
    output logic [CNT_WIDTH-1:0]       dec_count
);

    function automatic logic [FUNCT_WIDTH-1:0] alu_funct(input logic [2:0] f3);
        logic [FUNCT_WIDTH-1:0] r;
        unique case (f3)
            3'd0: r = FUNCT_ADD;
            3'd1: r = FUNCT_SLL;
            3'd2: r = FUNCT_SLT;
            3'd3: r = FUNCT_SLTU;
            3'd4: r = FUNCT_XOR;
            3'd5: r = FUNCT_SRL;
            3'd6: r = FUNCT_OR;
            default: r = FUNCT_AND;
        endcase
        return r;
    endfunction

    function automatic logic [FUNCT_WIDTH-1:0] mem_funct(input logic [2:0] f3);
        logic [FUNCT_WIDTH-1:0] r;
        unique case (f3)
            3'd0: r = FUNCT_MEM_BYTE;
            3'd1: r = FUNCT_MEM_HWORD;
            3'd2: r = FUNCT_MEM_WORD;
            3'd4: r = FUNCT_MEM_BYTEU;
            3'd5: r = FUNCT_MEM_HWORDU;
            default: r = FUNCT_NONE;
        endcase
        return r;
    endfunction

    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [IMM_WIDTH-1:0] imm_i;
    logic [IMM_WIDTH-1:0] imm_s;
    logic [IMM_WIDTH-1:0] imm_b;
    logic [IMM_WIDTH-1:0] imm_u;
    logic [IMM_WIDTH-1:0] imm_j;
    logic [IMM_WIDTH-1:0] imm_sh;

    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7],
                     inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12],
                     inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    dec_t decoded;
    logic legal;

    // Combinational decode of the incoming word; illegal encodings are zeroed
    always_comb begin
        decoded        = '0;
        decoded.opcode = inst[6:0];
        legal          = 1'b1;
        unique case (inst[6:0])
            OP_LUI: begin
                decoded.inst_type = INST_TYPE_IMM;
                decoded.imm       = imm_u;
                decoded.rd        = inst[11:7];
            end
            OP_AUIPC: begin
                decoded.inst_type = INST_TYPE_AUIPC;
                decoded.imm       = imm_u;
                decoded.rd        = inst[11:7];
            end
            OP_JAL: begin
                decoded.inst_type = INST_TYPE_JAL;
                decoded.imm       = imm_j;
                decoded.rd        = inst[11:7];
            end
            OP_JALR: begin
                decoded.inst_type = INST_TYPE_JALR;
                decoded.imm       = imm_i;
                decoded.rd        = inst[11:7];
                decoded.rs1       = inst[19:15];
                legal             = (f3 == 3'd0);
            end
            OP_BRANCH: begin
                decoded.inst_type = INST_TYPE_BRANCH;
                decoded.imm       = imm_b;
                decoded.rs1       = inst[19:15];
                decoded.rs2       = inst[24:20];
                unique case (f3)
                    3'd0: decoded.funct = FUNCT_EQ;
                    3'd1: decoded.funct = FUNCT_NEQ;
                    3'd4: decoded.funct = FUNCT_LT;
                    3'd5: decoded.funct = FUNCT_GTE;
                    3'd6: decoded.funct = FUNCT_LTU;
                    3'd7: decoded.funct = FUNCT_GTEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                decoded.inst_type = INST_TYPE_LOAD;
                decoded.imm       = imm_i;
                decoded.rd        = inst[11:7];
                decoded.rs1       = inst[19:15];
                decoded.funct     = mem_funct(f3);
                legal             = (decoded.funct != FUNCT_NONE);
            end
            OP_STORE: begin
                decoded.inst_type = INST_TYPE_STORE;
                decoded.imm       = imm_s;
                decoded.rs1       = inst[19:15];
                decoded.rs2       = inst[24:20];
                decoded.funct     = mem_funct(f3);
                legal             = (f3 <= 3'd2);
            end
            OP_IMM: begin
                decoded.inst_type = INST_TYPE_INT_IMM;
                decoded.rd        = inst[11:7];
                decoded.rs1       = inst[19:15];
                decoded.funct     = alu_funct(f3);
                decoded.imm       = imm_i;
                if (f3 == 3'd1) begin
                    decoded.imm = imm_sh;
                    legal       = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    decoded.imm = imm_sh;
                    if (f7 == 7'h20)
                        decoded.funct = FUNCT_SRA;
                    else
                        legal = (f7 == 7'h00);
                end
            end
            OP_REG: begin
                decoded.inst_type = INST_TYPE_INT_REG;
                decoded.rd        = inst[11:7];
                decoded.rs1       = inst[19:15];
                decoded.rs2       = inst[24:20];
                decoded.funct     = alu_funct(f3);
                if (f7 == 7'h20) begin
                    if (f3 == 3'd0)
                        decoded.funct = FUNCT_SUB;
                    else if (f3 == 3'd5)
                        decoded.funct = FUNCT_SRA;
                    else
                        legal = 1'b0;
                end else begin
                    legal = (f7 == 7'h00);
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            decoded           = '0;
            decoded.opcode    = inst[6:0];
            decoded.inst_type = INST_TYPE_ILLEGAL;
            decoded.illegal   = 1'b1;
        end
    end

    dec_t                out_q;
    dec_t                skid_q;
    logic [PC_WIDTH-1:0] out_pc;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                out_valid;
    logic                skid_valid;
    logic                accept;
    logic                retire;

    assign inst_ready = ~skid_valid;
    assign dec_valid  = out_valid;
    assign accept     = inst_valid & inst_ready;
    assign retire     = out_valid & dec_ready;

    // Two-entry FIFO: output register plus skid register, flushable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_pc     <= '0;
            skid_pc    <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (retire) begin
                out_q      <= skid_q;
                out_pc     <= skid_pc;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || dec_ready) begin
                out_q     <= decoded;
                out_pc    <= inst_pc;
                out_valid <= 1'b1;
            end else begin
                skid_q     <= decoded;
                skid_pc    <= inst_pc;
                skid_valid <= 1'b1;
            end
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed output handshakes, including one in a flush cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dec_count <= '0;
        else if (retire)
            dec_count <= dec_count + 1'b1;
    end

    assign dec_pc    = out_pc;
    assign opcode    = out_q.opcode;
    assign inst_type = out_q.inst_type;
    assign imm       = out_q.imm;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign funct     = out_q.funct;
    assign illegal   = out_q.illegal;

endmodule
